// File: rtl/deser_pkg.sv
// Shared types and default parameters for the serial-to-parallel word queue.
package deser_pkg;

   localparam int WIDTH_DEF      = 8;
   localparam int DEPTH_DEF      = 8;
   localparam int SAMPLE_DIV_DEF = 10;
   localparam int LSB_FIRST_DEF  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } deser_state_e;

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through word queue; pop on empty is ignored, push+pop when full both succeed.
module word_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clock1M,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock1M) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clock1M or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/deser_queue.sv
// Samples a serial stream into WIDTH-bit words and queues them for a consumer.
//   state | meaning
//   IDLE  | no partial word, waiting for a sample tick with write_in high
//   SHIFT | partial word being assembled
//   HOLD  | complete word waiting for queue space; incoming bits are dropped
module deser_queue
   import deser_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
   parameter int LSB_FIRST  = LSB_FIRST_DEF
) (
   input  logic                   clock1M,
   input  logic                   reset,
   input  logic                   data_in,
   input  logic                   write_in,
   input  logic                   dequeue_in,
   input  logic                   clear_in,
   output logic [WIDTH-1:0]       data_out,
   output logic                   data_valid,
   output logic [$clog2(DEPTH):0] len_out,
   output logic                   status_out,
   output logic                   overflow_out
);
   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int BW = $clog2(WIDTH);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);

   logic [1:0]             rst_pipe;
   logic                   rst_n;
   logic [CW-1:0]          sample_cnt;
   logic                   tick;
   deser_state_e           state;
   deser_state_e           state_next;
   logic [BW-1:0]          bit_cnt;
   logic [BW-1:0]          bit_cnt_next;
   logic [WIDTH-1:0]       shift_reg;
   logic [WIDTH-1:0]       shift_next;
   logic [WIDTH-1:0]       shifted;
   logic [WIDTH-1:0]       hold_reg;
   logic [WIDTH-1:0]       hold_next;
   logic                   push;
   logic                   ovf_set;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [WIDTH-1:0]       fifo_head;

   // Assertion is immediate; release reaches the rest of the block two edges later.
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_n = rst_pipe[1];

   assign tick = (sample_cnt == SAMPLE_LAST);

   always_ff @(posedge clock1M or negedge rst_n) begin
      if (!rst_n) sample_cnt <= '0;
      else        sample_cnt <= tick ? '0 : sample_cnt + CW'(1);
   end

   assign shifted = (LSB_FIRST != 0) ? {data_in, shift_reg[WIDTH-1:1]}
                                     : {shift_reg[WIDTH-2:0], data_in};

   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shift_next   = shift_reg;
      hold_next    = hold_reg;
      push         = 1'b0;
      ovf_set      = 1'b0;
      case (state)
         IDLE, SHIFT: begin
            if (tick) begin
               if (write_in) begin
                  if (bit_cnt == BIT_LAST) begin
                     hold_next    = shifted;
                     shift_next   = '0;
                     bit_cnt_next = '0;
                     state_next   = HOLD;
                  end else begin
                     shift_next   = shifted;
                     bit_cnt_next = bit_cnt + BW'(1);
                     state_next   = SHIFT;
                  end
               end else begin
                  shift_next   = '0;
                  bit_cnt_next = '0;
                  state_next   = IDLE;
               end
            end
         end
         HOLD: begin
            ovf_set = tick && write_in;
            if (!fifo_full || dequeue_in) begin
               push       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock1M or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         hold_reg  <= '0;
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         shift_reg <= shift_next;
         hold_reg  <= hold_next;
      end
   end

   // A dropped bit outranks a same-cycle clear.
   always_ff @(posedge clock1M or negedge rst_n) begin
      if (!rst_n)        overflow_out <= 1'b0;
      else if (ovf_set)  overflow_out <= 1'b1;
      else if (clear_in) overflow_out <= 1'b0;
   end

   assign status_out = (state != HOLD);

   word_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock1M (clock1M),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (dequeue_in),
      .din     (hold_reg),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count),
      .head    (fifo_head)
   );

   // Consumer-facing view lags the queue by one edge.
   always_ff @(posedge clock1M or negedge rst_n) begin
      if (!rst_n) begin
         len_out    <= '0;
         data_valid <= 1'b0;
         data_out   <= '0;
      end else begin
         len_out    <= fifo_count;
         data_valid <= !fifo_empty;
         data_out   <= fifo_empty ? '0 : fifo_head;
      end
   end

endmodule

// File: tb/tb_deser_queue.sv
// Bench for deser_queue: MSB-first and LSB-first instances against a queue-based reference model.
module tb_deser_queue;
   import deser_pkg::*;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int SD = 5;

   logic clock1M    = 1'b0;
   logic reset      = 1'b1;
   logic data_in    = 1'b0;
   logic write_in   = 1'b0;
   logic dequeue_in = 1'b0;
   logic clear_in   = 1'b0;

   logic [W-1:0] dout_m, dout_l;
   logic         valid_m, valid_l, stat_m, stat_l, ovf_m, ovf_l;
   logic [3:0]   len_m, len_l;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clock1M = ~clock1M;

   deser_queue #(.WIDTH(W), .DEPTH(D), .SAMPLE_DIV(SD), .LSB_FIRST(0)) dut_m (
      .clock1M(clock1M), .reset(reset), .data_in(data_in), .write_in(write_in),
      .dequeue_in(dequeue_in), .clear_in(clear_in), .data_out(dout_m),
      .data_valid(valid_m), .len_out(len_m), .status_out(stat_m), .overflow_out(ovf_m));

   deser_queue #(.WIDTH(W), .DEPTH(D), .SAMPLE_DIV(SD), .LSB_FIRST(1)) dut_l (
      .clock1M(clock1M), .reset(reset), .data_in(data_in), .write_in(write_in),
      .dequeue_in(dequeue_in), .clear_in(clear_in), .data_out(dout_l),
      .data_valid(valid_l), .len_out(len_l), .status_out(stat_l), .overflow_out(ovf_l));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rev(input logic [W-1:0] x);
      for (int i = 0; i < W; i++) rev[i] = x[W-1-i];
   endfunction

   // Reference model: bits collected in arrival order, complete words queued in arrival order.
   int           m_sync, m_cnt;
   bit           m_holding, m_tk, m_pop, m_push;
   bit           m_bits[$];
   logic [W-1:0] m_word;
   logic [W-1:0] q[$];
   logic [3:0]   e_len;
   logic         e_valid, e_stat, e_ovf;
   logic [W-1:0] e_dm;

   always @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         m_sync = 0; m_cnt = 0; m_holding = 0; m_word = '0;
         m_bits.delete(); q.delete();
         e_len = 0; e_valid = 0; e_dm = '0; e_ovf = 0;
      end else if (m_sync < 2) begin
         m_sync++;
      end else begin
         m_tk  = (m_cnt == SD - 1);
         m_cnt = m_tk ? 0 : m_cnt + 1;
         e_len   = 4'(q.size());
         e_valid = (q.size() != 0);
         e_dm    = e_valid ? q[0] : '0;
         m_pop   = dequeue_in && (q.size() > 0);
         m_push  = m_holding && ((q.size() < D) || dequeue_in);
         if (m_holding && m_tk && write_in) e_ovf = 1;
         else if (clear_in)                 e_ovf = 0;
         if (m_pop) void'(q.pop_front());
         if (m_push) begin
            q.push_back(m_word);
            m_holding = 0;
         end else if (!m_holding && m_tk) begin
            if (write_in) begin
               m_bits.push_back(data_in);
               if (m_bits.size() == W) begin
                  for (int i = 0; i < W; i++) m_word[W-1-i] = m_bits[i];
                  m_bits.delete();
                  m_holding = 1;
               end
            end else begin
               m_bits.delete();
            end
         end
      end
      e_stat = !m_holding;
   end

   always @(negedge clock1M) begin
      if (chk_en) begin
         check("len_m", len_m, e_len);       check("len_l", len_l, e_len);
         check("valid_m", valid_m, e_valid); check("valid_l", valid_l, e_valid);
         check("data_m", dout_m, e_dm);      check("data_l", dout_l, rev(e_dm));
         check("status_m", stat_m, e_stat);  check("status_l", stat_l, e_stat);
         check("ovf_m", ovf_m, e_ovf);       check("ovf_l", ovf_l, e_ovf);
      end
   end

   // Callers start at a negedge; returns at the negedge just after the sampling edge.
   task automatic send_bit(input logic b);
      int g = 0;
      data_in  = b;
      write_in = 1'b1;
      while (!(m_sync == 2 && m_cnt == SD - 1)) begin
         @(negedge clock1M);
         g++;
         if (g > 4 * SD) begin
            bad++;
            $display("FAIL tick_wait: no sample tick within %0d cycles", g);
            break;
         end
      end
      @(negedge clock1M);
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
      write_in = 1'b0;
   endtask

   task automatic pop_once();
      dequeue_in = 1'b1;
      @(negedge clock1M);
      dequeue_in = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_len"}, len_m, 0);      check({tag, "_valid"}, valid_m, 0);
      check({tag, "_data_m"}, dout_m, 0);  check({tag, "_data_l"}, dout_l, 0);
      check({tag, "_status"}, stat_m, 1);  check({tag, "_ovf"}, ovf_m, 0);
      check({tag, "_len_l"}, len_l, 0);    check({tag, "_status_l"}, stat_l, 1);
   endtask

   typedef struct {
      logic [W-1:0] stream;
      logic [W-1:0] exp_m;
      logic [W-1:0] exp_l;
   } vec_t;

   vec_t         vt[6];
   logic [W-1:0] fw[8];
   int           p;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'b10110010, 8'hB2, 8'h4D};
      vt[1] = '{8'h0F, 8'h0F, 8'hF0};
      vt[2] = '{8'h12, 8'h12, 8'h48};
      vt[3] = '{8'hFF, 8'hFF, 8'hFF};
      vt[4] = '{8'h00, 8'h00, 8'h00};
      vt[5] = '{8'hC1, 8'hC1, 8'h83};

      #1 reset = 1'b0;
      #1 check_reset_outputs("por");
      chk_en = 1'b1;
      repeat (3) @(negedge clock1M);
      reset = 1'b1;
      repeat (4) @(negedge clock1M);
      check_reset_outputs("post_release");

      // single words, bit order and two-cycle latency
      for (int i = 0; i < 6; i++) begin
         send_word(vt[i].stream);
         @(negedge clock1M);
         @(negedge clock1M);
         check("vec_data_m", dout_m, vt[i].exp_m);
         check("vec_data_l", dout_l, vt[i].exp_l);
         check("vec_len", len_m, 1);
         check("vec_valid", valid_m, 1);
         pop_once();
         @(negedge clock1M);
         check("vec_len_after_pop", len_m, 0);
         check("vec_valid_after_pop", valid_m, 0);
      end

      // pop while empty
      dequeue_in = 1'b1;
      repeat (3) begin
         @(negedge clock1M);
         check("empty_pop_len", len_m, 0);
         check("empty_pop_valid", valid_m, 0);
      end
      dequeue_in = 1'b0;

      // partial word abandoned after three bits
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      write_in = 1'b0;
      repeat (SD + 1) @(negedge clock1M);
      check("abort_state", dut_m.state, IDLE);
      check("abort_status", stat_m, 1);
      check("abort_len", len_m, 0);
      send_word(8'h6C);
      @(negedge clock1M);
      @(negedge clock1M);
      check("after_abort_data_m", dout_m, 8'h6C);
      check("after_abort_data_l", dout_l, 8'h36);
      check("after_abort_len", len_m, 1);
      pop_once();
      @(negedge clock1M);

      // fill, overflow, set-beats-clear, push on pop when full
      for (int i = 0; i < D; i++) begin
         fw[i] = 8'(i * 17 + 3);
         send_word(fw[i]);
      end
      @(negedge clock1M);
      @(negedge clock1M);
      check("full_len", len_m, 8);
      send_word(8'hE7);
      @(negedge clock1M);
      @(negedge clock1M);
      check("hold_status", stat_m, 0);
      check("hold_ovf_before", ovf_m, 0);
      send_bit(1'b1);
      check("ovf_set", ovf_m, 1);
      clear_in = 1'b1;
      send_bit(1'b0);
      check("ovf_set_wins", ovf_m, 1);
      write_in = 1'b0;
      @(negedge clock1M);
      clear_in = 1'b0;
      check("ovf_cleared", ovf_m, 0);
      check("still_hold", stat_m, 0);
      pop_once();
      check("push_on_pop_status", stat_m, 1);
      @(negedge clock1M);
      check("push_on_pop_len", len_m, 8);
      check("push_on_pop_head", dout_m, fw[1]);

      // reset while a word waits in HOLD
      send_word(8'h5E);
      @(negedge clock1M);
      check("hold2_status", stat_m, 0);
      #2 reset = 1'b0;
      #1 check_reset_outputs("hold_reset");
      check("hold_reset_state", dut_m.state, IDLE);
      @(negedge clock1M);
      reset = 1'b1;
      repeat (6 * SD) @(negedge clock1M);
      check("hold_reset_no_push_len", len_m, 0);
      check("hold_reset_no_push_valid", valid_m, 0);

      // randomized traffic, filling then draining
      for (int c = 0; c < 4000; c++) begin
         p = (c < 2000) ? 2 : 45;
         write_in   = ($urandom_range(0, 15) != 0);
         data_in    = 1'($urandom_range(0, 1));
         dequeue_in = ($urandom_range(0, 99) < p);
         clear_in   = ($urandom_range(0, 29) == 0);
         @(negedge clock1M);
      end
      write_in = 1'b0; dequeue_in = 1'b0; clear_in = 1'b0;
      repeat (4) @(negedge clock1M);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
